// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit-PC / 16-bit-instruction core: widths, opcodes,
// instruction field positions and the ID/EX pipeline payload.
package core_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PC_W    = 8;
    localparam int unsigned NREGS   = 8;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM6_W  = 6;
    localparam int unsigned IMM8_W  = 8;

    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_LSB = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h5;
    localparam logic [OP_W-1:0] OP_LD   = 4'h6;
    localparam logic [OP_W-1:0] OP_ST   = 4'h7;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'h8;
    localparam logic [OP_W-1:0] OP_BNE  = 4'h9;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OP_W-1:0] OP_NOP  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'hE000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [PC_W-1:0]   pc;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
    } id_ex_t;

    // Opcodes whose rs2 field names a real source register
    function automatic logic uses_rs2(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ST, OP_BEQ, OP_BNE};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX pipeline bundle from decode to execute.
interface decode_stage_if;
    import core_pkg::*;

    logic              ex_valid;
    logic [OP_W-1:0]   ex_opcode;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rs1_data;
    logic [DATA_W-1:0] ex_rs2_data;
    logic [DATA_W-1:0] ex_imm;
    logic [PC_W-1:0]   ex_pc;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;

    modport master (
        output ex_valid, ex_opcode, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
    );

endinterface

// File: rtl/reg_file.sv
// 8x16 register file: two combinational read ports with write-through bypass,
// one synchronous write port, r0 hardwired to zero.
module reg_file
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write wins over the stored value so decode never reads stale data
    assign rd_data_a = (rd_addr_a == '0)                    ? '0      :
                       (wr_en && wr_addr == rd_addr_a)      ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0)                    ? '0      :
                       (wr_en && wr_addr == rd_addr_b)      ? wr_data : regs[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, load-use hazard detection, jump redirect and halt FSM.
// Optional DECODE_PERF_EN adds saturating bubble/stall performance counters.
module decode_stage
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              valid_in,
    input  logic              flush_in,
    input  logic              stall_in,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic              jump_flush,
    output logic [PC_W-1:0]   jump_target,
    output logic              halt_out,
    decode_stage_if.master    id_ex
`ifdef DECODE_PERF_EN
   ,output logic [15:0]       perf_bubbles
   ,output logic [15:0]       perf_stalls
`endif
);

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [IMM6_W-1:0] imm6;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              hazard_c, accept_c;
    id_ex_t            dec, ex_q, ex_d;
    dec_state_e        state_q, state_d;

    assign op   = instr_in[OP_LSB  +: OP_W];
    assign rd   = instr_in[RD_LSB  +: REG_AW];
    assign rs1  = instr_in[RS1_LSB +: REG_AW];
    assign rs2  = instr_in[RS2_LSB +: REG_AW];
    assign imm6 = instr_in[IMM6_W-1:0];

    reg_file u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_data),
        .rd_addr_b (rs2),
        .rd_data_b (rs2_data),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // Load in ID/EX whose rd feeds the instruction now in decode
    assign hazard_c = valid_in && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((rs1 == ex_q.rd) || (uses_rs2(op) && (rs2 == ex_q.rd)));
    assign accept_c = valid_in && (state_q == ST_RUN) && !flush_in && !stall_in && !hazard_c;

    assign stall_out   = hazard_c || stall_in || (state_q == ST_HALTED);
    assign jump_flush  = accept_c && (op == OP_JMP);
    assign jump_target = instr_in[IMM8_W-1:0];
    assign halt_out    = (state_q == ST_HALTED);

    always_comb begin
        dec           = '0;
        dec.valid     = valid_in;
        dec.opcode    = op;
        dec.rd        = rd;
        dec.rs1_data  = rs1_data;
        dec.rs2_data  = rs2_data;
        dec.imm       = {{(DATA_W-IMM6_W){imm6[IMM6_W-1]}}, imm6};
        dec.pc        = pc_in;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: dec.reg_write = (rd != '0);
            OP_LD: begin
                dec.reg_write = (rd != '0);
                dec.mem_read  = 1'b1;
            end
            OP_ST:          dec.mem_write = 1'b1;
            OP_BEQ, OP_BNE: dec.branch    = 1'b1;
            default:        ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
        end
    end

    // Slot update priority: flush, back-pressure hold, load-use bubble, capture
    always_comb begin
        state_d = state_q;
        ex_d    = ex_q;
        if (flush_in) begin
            ex_d.valid = 1'b0;
        end else if (stall_in) begin
            ex_d = ex_q;
        end else if (hazard_c) begin
            ex_d.valid = 1'b0;
        end else begin
            ex_d = dec;
        end
        if (state_q == ST_HALTED) ex_d.valid = 1'b0;
        if (accept_c && op == OP_HALT) state_d = ST_HALTED;
    end

    assign id_ex.ex_valid     = ex_q.valid && (state_q == ST_RUN);
    assign id_ex.ex_opcode    = ex_q.opcode;
    assign id_ex.ex_rd        = ex_q.rd;
    assign id_ex.ex_rs1_data  = ex_q.rs1_data;
    assign id_ex.ex_rs2_data  = ex_q.rs2_data;
    assign id_ex.ex_imm       = ex_q.imm;
    assign id_ex.ex_pc        = ex_q.pc;
    assign id_ex.ex_reg_write = ex_q.reg_write;
    assign id_ex.ex_mem_read  = ex_q.mem_read;
    assign id_ex.ex_mem_write = ex_q.mem_write;
    assign id_ex.ex_branch    = ex_q.branch;

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_bubbles <= '0;
            perf_stalls  <= '0;
        end else begin
            if (!flush_in && !stall_in && hazard_c && perf_bubbles != 16'hFFFF)
                perf_bubbles <= perf_bubbles + 16'd1;
            if (stall_in && perf_stalls != 16'hFFFF)
                perf_stalls <= perf_stalls + 16'd1;
        end
    end
`endif

endmodule
